// File: rtl/fwd_pkg.sv
// Shared constants and the shadow-pipe entry layout for the forwarding unit.
package fwd_pkg;

  // Default geometry of one shadow-pipe entry.
  localparam int PKG_REG_W   = 4;
  localparam int PKG_NUM_SRC = 2;

  // Operand-select value meaning "take the register-file read".
  localparam int SEL_REGFILE = 0;

  // One shadow-pipe entry at the default geometry. The top level keeps the
  // same fields as separate packed vectors so that REG_W/NUM_SRC can be
  // overridden per instance.
  typedef struct packed {
    logic                               valid;
    logic [PKG_REG_W-1:0]               dest;
    logic                               wb_en;
    logic                               mem_read;
    logic [PKG_NUM_SRC*PKG_REG_W-1:0]   src;
    logic [PKG_NUM_SRC-1:0]             src_used;
  } sb_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Per-source forwarding match: compares one EX source against the
// destinations of stages 1..DEPTH and picks the youngest producer.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int DEPTH = 2,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic                   fwd_en,
  input  logic                   src_valid,
  input  logic [REG_W-1:0]       src,
  input  logic [DEPTH-1:0]       stage_wr,
  input  logic [DEPTH*REG_W-1:0] stage_dest,
  output logic [SEL_W-1:0]       sel
);

  // Bit gi corresponds to stage gi+1.
  logic [DEPTH-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign hit[gi] = fwd_en & src_valid & stage_wr[gi] &
                       (stage_dest[gi*REG_W +: REG_W] == src);
    end
  endgenerate

  // Lowest-index priority encoder: scan oldest to youngest so the youngest
  // matching stage overwrites the result last.
  always_comb begin
    sel = SEL_W'(SEL_REGFILE);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit[k]) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard unit: a shadow pipeline recording every issued
// instruction's destination, producing EX operand selects, an ID stall
// request and a saturating stall counter.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_W   = 4,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fwd_en,
  input  logic                     freeze,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [REG_W-1:0]         id_dest,
  input  logic                     id_wb_en,
  input  logic                     id_mem_read,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  output logic [NUM_SRC*SEL_W-1:0] ex_sel,
  output logic                     stall,
  output logic [15:0]              stall_cnt
);

  // Shadow pipe, entry k at index k (0 = EX). Only entry 0 is ever asked
  // for its sources and load flag, so older copies of those fields are
  // not kept.
  logic [DEPTH:0]             valid_reg;
  logic [DEPTH:0]             wb_en_reg;
  logic [REG_W-1:0]           dest_reg [0:DEPTH];
  logic                       mem_read_reg;
  logic [NUM_SRC*REG_W-1:0]   src_reg;
  logic [NUM_SRC-1:0]         src_used_reg;
  logic [15:0]                stall_cnt_reg;

  logic                       valid_next;
  logic                       hazard;
  logic [DEPTH-1:0]           stage_wr;
  logic [DEPTH*REG_W-1:0]     stage_dest;

  // An ID instruction enters EX only when it is real, not held and not killed.
  assign valid_next = id_valid & ~stall & ~flush;

  // RAW hazard detection against the current ID sources.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i]) begin
        if (fwd_en) begin
          // Only a load in EX cannot be forwarded in time.
          if (valid_reg[0] && wb_en_reg[0] && mem_read_reg &&
              (dest_reg[0] == id_src[i*REG_W +: REG_W])) begin
            hazard = 1'b1;
          end
        end else begin
          // Without forwarding, any in-flight writer blocks the consumer.
          for (int k = 0; k <= DEPTH; k++) begin
            if (valid_reg[k] && wb_en_reg[k] &&
                (dest_reg[k] == id_src[i*REG_W +: REG_W])) begin
              hazard = 1'b1;
            end
          end
        end
      end
    end
  end

  assign stall     = id_valid & ~flush & hazard;
  assign stall_cnt = stall_cnt_reg;

  genvar gi;
  generate
    // Flatten the writer view of stages 1..DEPTH for the match units.
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      assign stage_wr[gi]                   = valid_reg[gi+1] & wb_en_reg[gi+1];
      assign stage_dest[gi*REG_W +: REG_W]  = dest_reg[gi+1];
    end

    // One match/priority unit per EX source operand.
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_match #(
        .REG_W (REG_W),
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
      ) u_match (
        .fwd_en     (fwd_en),
        .src_valid  (valid_reg[0] & src_used_reg[gi]),
        .src        (src_reg[gi*REG_W +: REG_W]),
        .stage_wr   (stage_wr),
        .stage_dest (stage_dest),
        .sel        (ex_sel[gi*SEL_W +: SEL_W])
      );
    end
  endgenerate

  // Advance the shadow pipe and count stall cycles unless frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg     <= '0;
      stall_cnt_reg <= '0;
    end else if (!freeze) begin
      valid_reg    <= {valid_reg[DEPTH-1:0], valid_next};
      wb_en_reg    <= {wb_en_reg[DEPTH-1:0], id_wb_en};
      dest_reg[0]  <= id_dest;
      for (int k = 1; k <= DEPTH; k++) begin
        dest_reg[k] <= dest_reg[k-1];
      end
      mem_read_reg <= id_mem_read;
      src_reg      <= id_src;
      src_used_reg <= id_src_used;
      if (stall && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: scenario tasks with a queue of
// expected EX selects pushed at issue and popped when the instruction is in EX.
module tb_fwd_scoreboard;

  logic        clk;
  logic        rst, fwd_en, freeze, flush, id_valid, id_wb_en, id_mem_read;
  logic [3:0]  id_dest;
  logic [7:0]  id_src;
  logic [1:0]  id_src_used;
  logic [3:0]  ex_sel;
  logic        stall;
  logic [15:0] stall_cnt;

  // Deep instance used only to reach counter saturation quickly.
  logic        b_rst, b_id_valid;
  logic [11:0] b_ex_sel;
  logic        b_stall;
  logic [15:0] b_stall_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  sb_q [$];
  logic [3:0]  exp_sel;

  fwd_scoreboard #(.REG_W(4), .NUM_SRC(2), .DEPTH(2)) dut (
    .clk (clk), .rst (rst), .fwd_en (fwd_en), .freeze (freeze), .flush (flush),
    .id_valid (id_valid), .id_dest (id_dest), .id_wb_en (id_wb_en),
    .id_mem_read (id_mem_read), .id_src (id_src), .id_src_used (id_src_used),
    .ex_sel (ex_sel), .stall (stall), .stall_cnt (stall_cnt)
  );

  fwd_scoreboard #(.REG_W(4), .NUM_SRC(2), .DEPTH(62)) dut_deep (
    .clk (clk), .rst (b_rst), .fwd_en (1'b0), .freeze (1'b0), .flush (1'b0),
    .id_valid (b_id_valid), .id_dest (4'd5), .id_wb_en (1'b1),
    .id_mem_read (1'b0), .id_src (8'h05), .id_src_used (2'b01),
    .ex_sel (b_ex_sel), .stall (b_stall), .stall_cnt (b_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [3:0] d, input logic wb,
                          input logic mr, input logic [3:0] s0,
                          input logic [3:0] s1, input logic [1:0] used);
    id_valid    = v;
    id_dest     = d;
    id_wb_en    = wb;
    id_mem_read = mr;
    id_src      = {s1, s0};
    id_src_used = used;
  endtask

  task automatic do_reset();
    drive_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fwd_en = 1'b1; freeze = 1'b0; flush = 1'b0;
    do_reset();
    drive_id(1'b1, 4'd6, 1'b1, 1'b0, 4'd0, 4'd0, 2'b11);
    #1;
    checks++; if (ex_sel !== 4'h0) begin $display("FAIL reset_sel got=%h exp=0", ex_sel); errors++; end
    checks++; if (stall !== 1'b0) begin $display("FAIL reset_stall got=%b exp=0", stall); errors++; end
    checks++; if (stall_cnt !== 16'h0) begin $display("FAIL reset_cnt got=%h exp=0", stall_cnt); errors++; end
    $display("txn reset ex_sel=%h stall=%b cnt=%0d", ex_sel, stall, stall_cnt);
    drive_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
  endtask

  task automatic test_defaults();
    drive_id(1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);   // ADD r1
    tick();
    drive_id(1'b1, 4'd7, 1'b1, 1'b0, 4'd1, 4'd0, 2'b01);   // consumer of r1
    sb_q.push_back(4'h1);
    #1;
    checks++; if (stall !== 1'b0) begin $display("FAIL defaults_stall got=%b exp=0", stall); errors++; end
    tick();
    exp_sel = sb_q.pop_front();
    checks++; if (ex_sel !== exp_sel) begin $display("FAIL defaults_sel1 got=%h exp=%h", ex_sel, exp_sel); errors++; end
    $display("txn defaults_c1 ex_sel=%h stall=%b", ex_sel, stall);
    drive_id(1'b1, 4'd8, 1'b1, 1'b0, 4'd1, 4'd0, 2'b01);   // second consumer of r1
    sb_q.push_back(4'h2);
    tick();
    exp_sel = sb_q.pop_front();
    checks++; if (ex_sel !== exp_sel) begin $display("FAIL defaults_sel2 got=%h exp=%h", ex_sel, exp_sel); errors++; end
    $display("txn defaults_c2 ex_sel=%h stall=%b", ex_sel, stall);
    drive_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
    tick();
  endtask

  task automatic test_back_to_back();
    drive_id(1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);   // older writer r3
    tick();
    drive_id(1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);   // younger writer r3
    tick();
    drive_id(1'b1, 4'd9, 1'b1, 1'b0, 4'd3, 4'd3, 2'b11);   // both sources r3
    sb_q.push_back(4'h5);
    tick();
    exp_sel = sb_q.pop_front();
    checks++; if (ex_sel !== exp_sel) begin $display("FAIL b2b_youngest got=%h exp=%h", ex_sel, exp_sel); errors++; end
    $display("txn b2b_used ex_sel=%h", ex_sel);
    drive_id(1'b1, 4'd10, 1'b1, 1'b0, 4'd3, 4'd3, 2'b00);  // r3 named but unused
    sb_q.push_back(4'h0);
    tick();
    exp_sel = sb_q.pop_front();
    checks++; if (ex_sel !== exp_sel) begin $display("FAIL b2b_unused got=%h exp=%h", ex_sel, exp_sel); errors++; end
    $display("txn b2b_unused ex_sel=%h", ex_sel);
    drive_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
  endtask

  task automatic test_load_use();
    do_reset();
    drive_id(1'b1, 4'd2, 1'b1, 1'b1, 4'd0, 4'd0, 2'b00);   // LDR r2
    tick();
    drive_id(1'b1, 4'd11, 1'b1, 1'b0, 4'd2, 4'd0, 2'b01);  // consumer of r2
    #1;
    checks++; if (stall !== 1'b1) begin $display("FAIL loaduse_stall got=%b exp=1", stall); errors++; end
    tick();
    checks++; if (stall !== 1'b0) begin $display("FAIL loaduse_release got=%b exp=0", stall); errors++; end
    checks++; if (stall_cnt !== 16'd1) begin $display("FAIL loaduse_cnt got=%0d exp=1", stall_cnt); errors++; end
    checks++; if (ex_sel !== 4'h0) begin $display("FAIL loaduse_bubble got=%h exp=0", ex_sel); errors++; end
    // The bubble follows the load down the pipe, so when the consumer is in
    // EX the load has moved one stage further (entry 2).
    sb_q.push_back(4'h2);
    tick();
    exp_sel = sb_q.pop_front();
    checks++; if (ex_sel !== exp_sel) begin $display("FAIL loaduse_sel got=%h exp=%h", ex_sel, exp_sel); errors++; end
    $display("txn load_use ex_sel=%h cnt=%0d", ex_sel, stall_cnt);
    drive_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
  endtask

  task automatic test_fwd_off();
    do_reset();
    fwd_en = 1'b0;
    drive_id(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);   // writer r5
    tick();
    drive_id(1'b1, 4'd12, 1'b1, 1'b0, 4'd5, 4'd0, 2'b01);  // consumer of r5
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (stall !== 1'b1) begin $display("FAIL fwdoff_stall%0d got=%b exp=1", c, stall); errors++; end
      checks++; if (ex_sel !== 4'h0) begin $display("FAIL fwdoff_sel%0d got=%h exp=0", c, ex_sel); errors++; end
      if (c == 1) begin
        // Writer is not a load, so turning forwarding on releases the stall.
        fwd_en = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin $display("FAIL fwdoff_toggle got=%b exp=0", stall); errors++; end
        fwd_en = 1'b0;
      end
      tick();
    end
    checks++; if (stall !== 1'b0) begin $display("FAIL fwdoff_release got=%b exp=0", stall); errors++; end
    sb_q.push_back(4'h0);
    tick();
    exp_sel = sb_q.pop_front();
    checks++; if (ex_sel !== exp_sel) begin $display("FAIL fwdoff_issue_sel got=%h exp=%h", ex_sel, exp_sel); errors++; end
    checks++; if (stall_cnt !== 16'd3) begin $display("FAIL fwdoff_cnt got=%0d exp=3", stall_cnt); errors++; end
    $display("txn fwd_off ex_sel=%h cnt=%0d", ex_sel, stall_cnt);
    fwd_en = 1'b1;
    drive_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
  endtask

  task automatic test_flush_freeze();
    do_reset();
    drive_id(1'b1, 4'd2, 1'b1, 1'b1, 4'd0, 4'd0, 2'b00);   // LDR r2
    tick();
    drive_id(1'b1, 4'd4, 1'b1, 1'b1, 4'd2, 4'd0, 2'b01);   // LDR r4 from r2
    #1;
    checks++; if (stall !== 1'b1) begin $display("FAIL flush_pre_stall got=%b exp=1", stall); errors++; end
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin $display("FAIL flush_stall got=%b exp=0", stall); errors++; end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (ex_sel !== 4'h0) begin $display("FAIL flush_bubble got=%h exp=0", ex_sel); errors++; end
    checks++; if (stall_cnt !== 16'd0) begin $display("FAIL flush_cnt got=%0d exp=0", stall_cnt); errors++; end
    sb_q.push_back(4'h2);
    tick();
    exp_sel = sb_q.pop_front();
    checks++; if (ex_sel !== exp_sel) begin $display("FAIL flush_reissue_sel got=%h exp=%h", ex_sel, exp_sel); errors++; end
    $display("txn flush ex_sel=%h cnt=%0d", ex_sel, stall_cnt);
    drive_id(1'b1, 4'd13, 1'b1, 1'b0, 4'd0, 4'd4, 2'b10);  // uses r4 on src1
    freeze = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (stall !== 1'b1) begin $display("FAIL freeze_stall%0d got=%b exp=1", c, stall); errors++; end
      checks++; if (ex_sel !== 4'h2) begin $display("FAIL freeze_sel%0d got=%h exp=2", c, ex_sel); errors++; end
      checks++; if (stall_cnt !== 16'd0) begin $display("FAIL freeze_cnt%0d got=%0d exp=0", c, stall_cnt); errors++; end
      tick();
    end
    freeze = 1'b0;
    tick();
    checks++; if (stall_cnt !== 16'd1) begin $display("FAIL unfreeze_cnt got=%0d exp=1", stall_cnt); errors++; end
    $display("txn freeze ex_sel=%h cnt=%0d", ex_sel, stall_cnt);
    drive_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
  endtask

  task automatic test_reset_midstream();
    drive_id(1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
    tick();
    drive_id(1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
    tick();
    drive_id(1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
    tick();
    // Without the reset this consumer would see r2 in entry 2.
    drive_id(1'b1, 4'd14, 1'b1, 1'b0, 4'd2, 4'd1, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fwd_en = 1'b0;
    drive_id(1'b1, 4'd15, 1'b1, 1'b0, 4'd3, 4'd0, 2'b01);
    #1;
    checks++; if (ex_sel !== 4'h0) begin $display("FAIL midrst_sel got=%h exp=0", ex_sel); errors++; end
    checks++; if (stall !== 1'b0) begin $display("FAIL midrst_stall got=%b exp=0", stall); errors++; end
    checks++; if (stall_cnt !== 16'd0) begin $display("FAIL midrst_cnt got=%0d exp=0", stall_cnt); errors++; end
    $display("txn reset_midstream ex_sel=%h stall=%b cnt=%0d", ex_sel, stall, stall_cnt);
    fwd_en = 1'b1;
    drive_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
  endtask

  task automatic test_saturation();
    int stalls = 0;
    int cycles = 0;
    b_rst = 1'b1;
    b_id_valid = 1'b0;
    tick();
    b_rst = 1'b0;
    #1;
    checks++; if (b_stall_cnt !== 16'd0) begin $display("FAIL sat_start got=%0d exp=0", b_stall_cnt); errors++; end
    // Every instruction reads the r5 its predecessor wrote, so each one
    // stalls until the predecessor drains from the deep shadow pipe.
    b_id_valid = 1'b1;
    while (stalls < 70000 && cycles < 80000) begin
      @(negedge clk);
      if (b_stall) stalls++;
      cycles++;
    end
    @(posedge clk);
    #1;
    b_id_valid = 1'b0;
    checks++; if (stalls < 70000) begin $display("FAIL sat_budget got=%0d exp=70000", stalls); errors++; end
    checks++; if (b_stall_cnt !== 16'hFFFF) begin $display("FAIL sat_cnt got=%h exp=ffff", b_stall_cnt); errors++; end
    $display("txn saturation stalls=%0d cnt=%h", stalls, b_stall_cnt);
  endtask

  initial begin
    rst = 1'b1; fwd_en = 1'b1; freeze = 1'b0; flush = 1'b0;
    b_rst = 1'b1; b_id_valid = 1'b0;
    drive_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
    tick();
    test_reset();
    test_defaults();
    test_back_to_back();
    test_load_use();
    test_fwd_off();
    test_flush_freeze();
    test_reset_midstream();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
